dma_chntrg_arb: RTL and testbench
=================================

Name: dma_chntrg_arb

Overview:
- Multi-channel DMA trigger front end with parameterised channel count.
- Per channel, replaces a single-bit trigger latch with a saturating pending-trigger counter, selectable edge/pulse hardware-trigger mode and a sticky overflow flag.
- A round-robin arbiter offers one pending channel at a time to the DMA channel engine over a valid/ready handshake.
- Sits between the ETB/software-trigger sources and the DMA channel controller.

Parameters:
- NUM_CH, 8, number of DMA channels (2..16).
- CNT_W, 4, pending-counter width; max count 2^CNT_W-1.
- ID_W, $clog2(NUM_CH), width of grant channel id.

Ports:
- hclk  in  1  clock.
- hrst  in  1  synchronous reset, active-high.
- chn_en  in  NUM_CH  per-channel enable.
- chn_edge_mode  in  NUM_CH  1 = count rising edges of etb_trg; 0 = count every cycle etb_trg is high.
- etb_trg  in  NUM_CH  hardware trigger from ETB.
- sfw_trg  in  NUM_CH  software trigger pulse.
- trg_clr  in  NUM_CH  clear pending count.
- ovf_clr  in  NUM_CH  clear sticky overflow.
- trg_pend  out  NUM_CH  count != 0, registered.
- trg_cnt  out  NUM_CH*CNT_W  pending counts; channel i at [i*CNT_W +: CNT_W].
- trg_ovf  out  NUM_CH  sticky overflow.
- gnt_vld  out  1  grant offered.
- gnt_id  out  ID_W  granted channel.
- gnt_rdy  in  1  engine accepts grant.

Behaviour:
- Reset (hrst=1 at posedge):
  - Clears all counts, trg_ovf, edge history, the rr pointer and the FSM (IDLE).
  - All outputs read 0 the following cycle.
  - Reset mid-offer drops gnt_vld with no decrement.
- Edge history etb_q updates every cycle regardless of chn_en.
  - hw_evt = chn_edge_mode ? (etb_trg & ~etb_q) : etb_trg.
  - Enabling a channel while etb_trg is already high in edge mode produces no event.
- Per-channel increment: inc = (hw_evt | sfw_trg) & chn_en. Simultaneous hw and sw triggers count as one event.
- Per-channel decrement: dec = gnt_vld & gnt_rdy & (gnt_id == i).
- Per-channel count update, priority high to low:
  1. ~chn_en: cnt <= 0.
  2. trg_clr: cnt <= inc ? 1 : 0. Set wins over clear; dec is ignored.
  3. inc & dec: unchanged.
  4. inc: if cnt == max, hold max and set trg_ovf; else cnt+1.
  5. dec: cnt-1. dec never occurs at cnt == 0 (checked by assertion).
- trg_ovf: sticky across disable.
  - ovf_clr clears it.
  - ovf_clr and a new overflow in the same cycle leaves it set.
- FSM IDLE:
  - If any trg_pend is set, capture gnt_id = first pending channel at or after rr_ptr, wrapping modulo NUM_CH.
  - Move to OFFER. gnt_vld=1 from the next cycle.
- FSM OFFER:
  - gnt_id and gnt_vld are held stable while ~gnt_rdy.
  - gnt_rdy=1: decrement the channel, rr_ptr <= gnt_id+1 (wrap to 0 at NUM_CH), go to IDLE.
  - Pending of the granted channel drops to 0 through clr or disable while ~gnt_rdy: withdraw, go to IDLE, no decrement.
  - gnt_rdy in the same cycle as clr/disable: the transfer counts as accepted and rr_ptr advances. The count follows the priority rules.
- Throughput: at most one grant per 2 cycles (IDLE bubble).
- Latency: first trigger to gnt_vld = 2 cycles (count register, then grant register).

Decomposition:
- Shared package dma_trg_pkg holds the FSM state encoding (IDLE, OFFER) and the CNT_W and NUM_CH defaults.
- One sub-module, dma_trg_rr_arb: round-robin find-first-from-pointer over NUM_CH request bits, returning the id and a found flag.
- Per-channel counters are written as a generate loop in the top module.

Test Plan:
- Reset / first grant: assert hrst 2 cycles mid-operation with ch3 cnt=5 → all counts 0, gnt_vld=0. Then sfw_trg[2] one cycle → trg_cnt[2]=1 next cycle, gnt_vld=1 with gnt_id=2 one cycle later.
- Edge vs pulse mode: etb_trg[0] high 4 cycles; edge_mode[0]=1 → cnt0=1; edge_mode[0]=0 → cnt0=4. Engine held off (gnt_rdy=0) throughout.
- Saturation / overflow: 17 sfw pulses on ch5 with gnt_rdy=0 → cnt5=15, trg_ovf[5]=1. ovf_clr[5] → trg_ovf[5]=0 and cnt5 stays 15.
- Round-robin: channels 1, 4, 6 pending, gnt_rdy=1 constantly → grants in order 1,4,6,1,4,6 until the counts drain; each count decrements once per accepted grant.
- Simultaneous events: cnt7=3 with inc & dec in the same cycle → cnt7=3. trg_clr and sfw_trg together → cnt=1. trg_clr with gnt_rdy on the offered channel → cnt=0 and rr_ptr advances.
- Withdraw: offer ch2 with gnt_rdy=0, deassert chn_en[2] → gnt_vld drops within 1 cycle with no decrement, and the next offer goes to the next pending channel.

Source files
------------

// File: rtl/dma_trg_pkg.sv
// dma_trg_pkg: shared grant-FSM encoding and default sizing for the DMA trigger front end
package dma_trg_pkg;
    typedef enum logic {IDLE, OFFER} state_t;
    localparam int NUM_CH_DEF = 8;
    localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/dma_trg_rr_arb.sv
// dma_trg_rr_arb: round-robin find-first pending request at or after ptr, wrapping modulo NUM_CH
module dma_trg_rr_arb
    import dma_trg_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int ID_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [ID_W-1:0]   id,
    output logic              found
);
    logic [ID_W-1:0] idx;
    // walk from the farthest candidate down so the nearest one at or after ptr wins
    always_comb begin
        id = '0;
        idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % NUM_CH);
            if (req[idx]) id = idx;
        end
    end
    assign found = |req;
endmodule

// File: rtl/dma_chntrg_arb.sv
// dma_chntrg_arb: per-channel saturating trigger counters with round-robin grant offer to the DMA engine
module dma_chntrg_arb
    import dma_trg_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ID_W = $clog2(NUM_CH)
) (
    input  logic                    hclk,
    input  logic                    hrst,
    input  logic [NUM_CH-1:0]       chn_en,
    input  logic [NUM_CH-1:0]       chn_edge_mode,
    input  logic [NUM_CH-1:0]       etb_trg,
    input  logic [NUM_CH-1:0]       sfw_trg,
    input  logic [NUM_CH-1:0]       trg_clr,
    input  logic [NUM_CH-1:0]       ovf_clr,
    output logic [NUM_CH-1:0]       trg_pend,
    output logic [NUM_CH*CNT_W-1:0] trg_cnt,
    output logic [NUM_CH-1:0]       trg_ovf,
    output logic                    gnt_vld,
    output logic [ID_W-1:0]         gnt_id,
    input  logic                    gnt_rdy
);
    localparam logic [CNT_W-1:0] MAX = '1;
    state_t state;
    logic [NUM_CH-1:0] etb_q, hw_evt, inc, dec, kill, req;
    logic [ID_W-1:0] rr_ptr, arb_id;
    logic found;
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic ovf [NUM_CH];
    assign hw_evt = (chn_edge_mode & etb_trg & ~etb_q) | (~chn_edge_mode & etb_trg);
    assign inc = (hw_evt | sfw_trg) & chn_en;
    assign kill = ~chn_en | (trg_clr & ~inc);
    // a channel being zeroed this cycle is never captured, so an offered channel always holds a count
    assign req = trg_pend & ~kill;
    always_ff @(posedge hclk) etb_q <= hrst ? '0 : etb_trg;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sat;
        assign dec[i] = gnt_vld & gnt_rdy & (gnt_id == ID_W'(i));
        assign sat = inc[i] & ~dec[i] & ~trg_clr[i] & (cnt[i] == MAX);
        assign trg_pend[i] = cnt[i] != '0;
        assign trg_cnt[i*CNT_W +: CNT_W] = cnt[i];
        assign trg_ovf[i] = ovf[i];
        always_ff @(posedge hclk) begin
            if (hrst) begin
                cnt[i] <= '0;
                ovf[i] <= 1'b0;
            end else begin
                cnt[i] <= ~chn_en[i] ? '0 :
                          trg_clr[i] ? CNT_W'(inc[i]) :
                          ((inc[i] & dec[i]) | sat) ? cnt[i] :
                          inc[i] ? cnt[i] + 1'b1 :
                          dec[i] ? cnt[i] - 1'b1 : cnt[i];
                ovf[i] <= sat | (ovf[i] & ~ovf_clr[i]);
                assert (!dec[i] || cnt[i] != '0);
            end
        end
    end
    dma_trg_rr_arb #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_arb (
        .req(req),
        .ptr(rr_ptr),
        .id(arb_id),
        .found(found)
    );
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state <= IDLE;
            gnt_vld <= 1'b0;
            gnt_id <= '0;
            rr_ptr <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                state <= OFFER;
                gnt_vld <= 1'b1;
                gnt_id <= arb_id;
            end
        end else if (gnt_rdy) begin
            state <= IDLE;
            gnt_vld <= 1'b0;
            rr_ptr <= (gnt_id == ID_W'(NUM_CH - 1)) ? '0 : gnt_id + 1'b1;
        end else if (kill[gnt_id]) begin
            state <= IDLE;
            gnt_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dma_chntrg_arb.sv
// tb_dma_chntrg_arb: randomized and directed stimulus checked by a queue-based scoreboard against a channel-level model
module tb_dma_chntrg_arb;
    localparam int N = 8, W = 4, IW = 3, MAXC = 15;
    logic hclk = 0, hrst, gnt_rdy, gnt_vld;
    logic [N-1:0] chn_en, chn_edge_mode, etb_trg, sfw_trg, trg_clr, ovf_clr, trg_pend, trg_ovf;
    logic [N*W-1:0] trg_cnt;
    logic [IW-1:0] gnt_id;
    always #5 hclk = ~hclk;
    dma_chntrg_arb #(.NUM_CH(N), .CNT_W(W), .ID_W(IW)) dut (
        .hclk(hclk), .hrst(hrst), .chn_en(chn_en), .chn_edge_mode(chn_edge_mode),
        .etb_trg(etb_trg), .sfw_trg(sfw_trg), .trg_clr(trg_clr), .ovf_clr(ovf_clr),
        .trg_pend(trg_pend), .trg_cnt(trg_cnt), .trg_ovf(trg_ovf),
        .gnt_vld(gnt_vld), .gnt_id(gnt_id), .gnt_rdy(gnt_rdy)
    );
    typedef struct {
        logic [N*W-1:0] cnt;
        logic [N-1:0] ovf;
        logic [N-1:0] pend;
        logic vld;
        logic [IW-1:0] id;
    } snap_t;
    snap_t exp_q[$];
    snap_t mexp, mon_e;
    int gnt_q[$];
    int acc_log[$];
    int checks = 0, errors = 0;
    int m_cnt[N];
    bit m_ovf[N], m_etbq[N];
    int m_rr = 0, m_gid = 0;
    bit m_off = 0;
    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int cnt_of(int c);
        return int'(trg_cnt[c*W +: W]);
    endfunction
    function automatic logic [N-1:0] rnd(int pct);
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) r[c] = ($urandom_range(99) < pct);
        return r;
    endfunction
    // reference model: evaluated mid-cycle on the inputs the next rising edge will sample
    always @(negedge hclk) begin
        int dch;
        bit ev[N], zn[N];
        bit set;
        if (!hrst && m_off && gnt_rdy) gnt_q.push_back(m_gid);
        if (hrst) begin
            for (int c = 0; c < N; c++) begin
                m_cnt[c] = 0;
                m_ovf[c] = 0;
                m_etbq[c] = 0;
            end
            m_rr = 0;
            m_off = 0;
            m_gid = 0;
        end else begin
            dch = (m_off && gnt_rdy) ? m_gid : -1;
            for (int c = 0; c < N; c++) begin
                ev[c] = chn_en[c] && ((chn_edge_mode[c] ? (etb_trg[c] && !m_etbq[c]) : etb_trg[c]) || sfw_trg[c]);
                zn[c] = !chn_en[c] || (trg_clr[c] && !ev[c]);
            end
            if (!m_off) begin
                for (int k = 0; k < N; k++)
                    if (m_cnt[(m_rr + k) % N] > 0 && !zn[(m_rr + k) % N]) begin
                        m_off = 1;
                        m_gid = (m_rr + k) % N;
                        break;
                    end
            end else if (gnt_rdy) begin
                m_off = 0;
                m_rr = (m_gid + 1) % N;
            end else if (zn[m_gid]) m_off = 0;
            for (int c = 0; c < N; c++) begin
                set = 0;
                if (!chn_en[c]) m_cnt[c] = 0;
                else if (trg_clr[c]) m_cnt[c] = ev[c] ? 1 : 0;
                else if (ev[c] && c == dch) begin end
                else if (ev[c]) begin
                    if (m_cnt[c] == MAXC) set = 1;
                    else m_cnt[c]++;
                end else if (c == dch) m_cnt[c]--;
                m_ovf[c] = set || (m_ovf[c] && !ovf_clr[c]);
                m_etbq[c] = etb_trg[c];
            end
        end
        for (int c = 0; c < N; c++) begin
            mexp.cnt[c*W +: W] = m_cnt[c][W-1:0];
            mexp.ovf[c] = m_ovf[c];
            mexp.pend[c] = m_cnt[c] != 0;
        end
        mexp.vld = m_off;
        mexp.id = m_gid[IW-1:0];
        exp_q.push_back(mexp);
    end
    // monitor: the oldest snapshot describes what the DUT shows during this cycle
    always @(negedge hclk) begin
        #1;
        if (exp_q.size() >= 2) begin
            mon_e = exp_q.pop_front();
            chk("trg_cnt", trg_cnt, mon_e.cnt);
            chk("trg_ovf", trg_ovf, mon_e.ovf);
            chk("trg_pend", trg_pend, mon_e.pend);
            chk("gnt_vld", gnt_vld, mon_e.vld);
            if (mon_e.vld) chk("gnt_id", gnt_id, mon_e.id);
            if (gnt_vld && gnt_rdy && !hrst) begin
                acc_log.push_back(int'(gnt_id));
                chk("accept_expected", gnt_q.size() > 0, 1);
                if (gnt_q.size() > 0) chk("accept_id", gnt_id, gnt_q.pop_front());
            end
        end
    end
    task automatic cyc();
        @(posedge hclk);
        #2;
    endtask
    task automatic quiet();
        chn_edge_mode = '0;
        etb_trg = '0;
        sfw_trg = '0;
        trg_clr = '0;
        ovf_clr = '0;
        gnt_rdy = 0;
        chn_en = '1;
    endtask
    task automatic rst_pulse();
        quiet();
        hrst = 1;
        cyc();
        hrst = 0;
    endtask
    task automatic rand_phase(int cycles, int sfw_pct, int rdy_pct);
        int b;
        repeat (cycles) begin
            b = $urandom_range(N - 1);
            if ($urandom_range(99) < 5) chn_en[b] = ~chn_en[b];
            b = $urandom_range(N - 1);
            if ($urandom_range(99) < 3) chn_edge_mode[b] = ~chn_edge_mode[b];
            etb_trg = rnd(30);
            sfw_trg = rnd(sfw_pct);
            trg_clr = rnd(2);
            ovf_clr = rnd(3);
            gnt_rdy = $urandom_range(99) < rdy_pct;
            hrst = $urandom_range(999) < 2;
            cyc();
        end
        hrst = 0;
    endtask
    initial begin
        int rr_exp[6] = '{1, 4, 6, 1, 4, 6};
        quiet();
        hrst = 1;
        repeat (2) cyc();
        hrst = 0;
        sfw_trg = 8'h08;
        repeat (5) cyc();
        sfw_trg = '0;
        cyc();
        chk("cnt3_pre_reset", cnt_of(3), 5);
        hrst = 1;
        repeat (2) cyc();
        chk("reset_cnt", trg_cnt, 0);
        chk("reset_vld", gnt_vld, 0);
        chk("reset_pend", trg_pend, 0);
        hrst = 0;
        sfw_trg = 8'h04;
        cyc();
        sfw_trg = '0;
        chk("first_cnt2", cnt_of(2), 1);
        chk("first_vld_early", gnt_vld, 0);
        cyc();
        chk("first_vld", gnt_vld, 1);
        chk("first_id", gnt_id, 2);
        rst_pulse();
        chn_edge_mode = 8'h01;
        etb_trg = 8'h01;
        repeat (4) cyc();
        etb_trg = '0;
        cyc();
        chk("edge_cnt0", cnt_of(0), 1);
        trg_clr = 8'h01;
        cyc();
        trg_clr = '0;
        chn_edge_mode = '0;
        etb_trg = 8'h01;
        repeat (4) cyc();
        etb_trg = '0;
        cyc();
        chk("pulse_cnt0", cnt_of(0), 4);
        rst_pulse();
        sfw_trg = 8'h20;
        repeat (17) cyc();
        sfw_trg = '0;
        cyc();
        chk("sat_cnt5", cnt_of(5), MAXC);
        chk("sat_ovf5", trg_ovf[5], 1);
        ovf_clr = 8'h20;
        cyc();
        ovf_clr = '0;
        chk("ovfclr_ovf5", trg_ovf[5], 0);
        chk("ovfclr_cnt5", cnt_of(5), MAXC);
        rst_pulse();
        acc_log.delete();
        sfw_trg = 8'b0101_0010;
        repeat (2) cyc();
        sfw_trg = '0;
        gnt_rdy = 1;
        repeat (20) cyc();
        gnt_rdy = 0;
        chk("rr_count", acc_log.size(), 6);
        for (int i = 0; i < 6 && i < acc_log.size(); i++) chk("rr_order", acc_log[i], rr_exp[i]);
        chk("rr_drained", trg_cnt, 0);
        rst_pulse();
        sfw_trg = 8'h80;
        repeat (3) cyc();
        gnt_rdy = 1;
        cyc();
        sfw_trg = '0;
        gnt_rdy = 0;
        chk("incdec_cnt7", cnt_of(7), 3);
        rst_pulse();
        sfw_trg = 8'h40;
        repeat (3) cyc();
        sfw_trg = '0;
        trg_clr = 8'h40;
        gnt_rdy = 1;
        cyc();
        trg_clr = '0;
        gnt_rdy = 0;
        chk("clr_rdy_cnt6", cnt_of(6), 0);
        sfw_trg = 8'h84;
        cyc();
        sfw_trg = '0;
        cyc();
        chk("clr_rdy_rr_vld", gnt_vld, 1);
        chk("clr_rdy_rr_id", gnt_id, 7);
        trg_clr = 8'h08;
        sfw_trg = 8'h08;
        cyc();
        trg_clr = '0;
        sfw_trg = '0;
        chk("clr_set_cnt3", cnt_of(3), 1);
        rst_pulse();
        sfw_trg = 8'h24;
        cyc();
        sfw_trg = '0;
        cyc();
        chk("wd_offer_id", gnt_id, 2);
        chn_en[2] = 0;
        cyc();
        chk("wd_vld", gnt_vld, 0);
        chk("wd_cnt2", cnt_of(2), 0);
        cyc();
        chk("wd_next_vld", gnt_vld, 1);
        chk("wd_next_id", gnt_id, 5);
        chn_en = '1;
        rand_phase(1500, 10, 50);
        rand_phase(800, 40, 10);
        rand_phase(1500, 5, 90);
        quiet();
        gnt_rdy = 1;
        repeat (40) cyc();
        @(negedge hclk);
        #3;
        chk("gnt_q_drained", gnt_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
